// File: rtl/mod_doubler_seq.sv
// Sequential modular scaler: oData = iData * 2^iShift mod iMod, applying one
// modular doubling per enabled cycle behind valid/ready handshakes on both sides.
module mod_doubler_seq #(
  parameter int BITWIDTH   = 32,
  parameter int SHIFTWIDTH = 6
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iEn,
  input  logic                  iClr,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [BITWIDTH-1:0]   iData,
  input  logic [BITWIDTH-1:0]   iMod,
  input  logic [SHIFTWIDTH-1:0] iShift,
  output logic                  oValid,
  input  logic                  iReady,
  output logic [BITWIDTH-1:0]   oData,
  output logic                  oBusy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } stateT;

  stateT                 r_state;
  stateT                 w_nextState;
  logic [BITWIDTH-1:0]   r_x;
  logic [BITWIDTH-1:0]   r_m;
  logic [SHIFTWIDTH-1:0] r_cnt;

  logic [BITWIDTH:0]     w_t;
  logic                  w_geMod;
  logic [BITWIDTH-1:0]   w_step;

  // The doubled value keeps its carry bit so the compare against m stays exact;
  // the subtraction itself only needs the low bits since the result fits.
  always_comb begin
    w_t     = {r_x, 1'b0};
    w_geMod = (w_t >= {1'b0, r_m});
    w_step  = w_geMod ? (w_t[BITWIDTH-1:0] - r_m) : w_t[BITWIDTH-1:0];
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (iClr) begin
      w_nextState = IDLE;
    end else if (iEn) begin
      case (r_state)
        IDLE: begin
          if (iValid) begin
            w_nextState = (iShift == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (r_cnt == SHIFTWIDTH'(1)) begin
            w_nextState = DONE;
          end
        end
        DONE: begin
          if (iReady) begin
            w_nextState = IDLE;
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  // RUN is only entered with a nonzero count and leaves at cnt == 1, so cnt never wraps.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_x   <= '0;
      r_m   <= '0;
      r_cnt <= '0;
    end else if (iClr) begin
      r_x   <= '0;
      r_m   <= '0;
      r_cnt <= '0;
    end else if (iEn) begin
      case (r_state)
        IDLE: begin
          if (iValid) begin
            r_x   <= iData;
            r_m   <= iMod;
            r_cnt <= iShift;
          end
        end
        RUN: begin
          r_x   <= w_step;
          r_cnt <= r_cnt - SHIFTWIDTH'(1);
        end
        default: begin
          r_x   <= r_x;
        end
      endcase
    end
  end

  assign oReady = (r_state == IDLE);
  assign oValid = (r_state == DONE);
  assign oBusy  = (r_state == RUN);
  assign oData  = r_x;

endmodule

// File: tb/tb_mod_doubler_seq.sv
// Bench for mod_doubler_seq: directed latency/handshake/reset cases plus a random
// regression, with results checked by a queue-based scoreboard against an arithmetic model.
module tb_mod_doubler_seq;

  localparam int BW = 8;
  localparam int SW = 6;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iEn;
  logic          iClr;
  logic          iValid;
  logic          iReady;
  logic [BW-1:0] iData;
  logic [BW-1:0] iMod;
  logic [SW-1:0] iShift;
  logic          oReady;
  logic          oValid;
  logic          oBusy;
  logic [BW-1:0] oData;

  int            cmpCount = 0;
  int            errCount = 0;
  logic [BW-1:0] expQ[$];

  mod_doubler_seq #(.BITWIDTH(BW), .SHIFTWIDTH(SW)) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr), .iValid(iValid),
    .oReady(oReady), .iData(iData), .iMod(iMod), .iShift(iShift),
    .oValid(oValid), .iReady(iReady), .oData(oData), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  // Reference: repeated doubling modulo m on plain integers.
  function automatic logic [BW-1:0] refModel(input int unsigned d, input int unsigned m,
                                             input int unsigned s);
    longint unsigned r = longint'(d);
    for (int unsigned i = 0; i < s; i++) r = (r * 2) % longint'(m);
    return BW'(r);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmpCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: pushes the model result on accept, pops and compares on output handshake,
  // and checks that a presented result never drops or changes before it is taken.
  task automatic monitorProc();
    logic          prevValid = 1'b0;
    logic          prevBreak = 1'b1;
    logic [BW-1:0] prevData = '0;
    logic          hs;
    logic [BW-1:0] e;
    forever begin
      @(negedge iClk);
      if (!iRst && prevValid && !prevBreak) begin
        checkOutput("valid held", 64'(oValid), 64'(1));
        checkOutput("data held", 64'(oData), 64'(prevData));
      end
      hs = oValid && iReady && iEn && !iClr && !iRst;
      if (hs) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected result", 64'(1), 64'(0));
        end else begin
          e = expQ.pop_front();
          checkOutput("scoreboard result", 64'(oData), 64'(e));
        end
      end
      if (iValid && oReady && iEn && !iClr && !iRst) begin
        expQ.push_back(refModel(32'(iData), 32'(iMod), 32'(iShift)));
      end
      prevValid = oValid && !iRst;
      prevBreak = hs || iClr || iRst;
      prevData  = oData;
    end
  endtask

  task automatic stepCycle();
    @(posedge iClk);
    #1;
  endtask

  // One directed transaction: accept, optional 2-cycle enable gap, latency/busy/data
  // checks, then hold DONE for holdCycles with iReady low before releasing it.
  task automatic applyStimulus(input string name, input logic [BW-1:0] d, input logic [BW-1:0] m,
                               input logic [SW-1:0] s, input int gapAt, input int expLat,
                               input logic [BW-1:0] expData, input int expBusy, input int holdCycles);
    int guard = 0;
    int lat;
    int busy = 0;
    while (!oReady && guard < 300) begin
      stepCycle();
      guard++;
    end
    checkOutput({name, " ready before accept"}, 64'(oReady), 64'(1));
    iReady = 1'b0;
    iValid = 1'b1;
    iData  = d;
    iMod   = m;
    iShift = s;
    stepCycle();
    iValid = 1'b0;
    lat    = 1;
    while (!oValid && lat < 300) begin
      if (oBusy) busy++;
      if (lat == gapAt) iEn = 1'b0;
      if (gapAt > 0 && lat == gapAt + 2) iEn = 1'b1;
      stepCycle();
      lat++;
    end
    iEn = 1'b1;
    checkOutput({name, " latency"}, 64'(lat), 64'(expLat));
    checkOutput({name, " data"}, 64'(oData), 64'(expData));
    checkOutput({name, " busy cycles"}, 64'(busy), 64'(expBusy));
    for (int i = 0; i < holdCycles; i++) begin
      iValid = 1'b1;
      stepCycle();
      checkOutput({name, " backpressure valid"}, 64'(oValid), 64'(1));
      checkOutput({name, " backpressure data"}, 64'(oData), 64'(expData));
      checkOutput({name, " backpressure ready"}, 64'(oReady), 64'(0));
    end
    iReady = 1'b1;
    stepCycle();
    iValid = 1'b0;
    iReady = 1'b0;
    checkOutput({name, " idle after handshake"}, 64'(oReady), 64'(1));
    checkOutput({name, " valid after handshake"}, 64'(oValid), 64'(0));
  endtask

  task automatic startOnly(input logic [BW-1:0] d, input logic [BW-1:0] m, input logic [SW-1:0] s);
    int guard = 0;
    while (!oReady && guard < 300) begin
      stepCycle();
      guard++;
    end
    iValid = 1'b1;
    iData  = d;
    iMod   = m;
    iShift = s;
    stepCycle();
    iValid = 1'b0;
  endtask

  initial begin
    int m;
    int guard;
    iRst = 1'b1; iEn = 1'b1; iClr = 1'b0; iValid = 1'b0; iReady = 1'b0;
    iData = '0; iMod = 8'd1; iShift = '0;
    fork
      monitorProc();
      begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
      end
    join_none

    #12;
    checkOutput("reset ready", 64'(oReady), 64'(1));
    checkOutput("reset valid", 64'(oValid), 64'(0));
    checkOutput("reset busy", 64'(oBusy), 64'(0));
    checkOutput("reset data", 64'(oData), 64'(0));
    stepCycle();
    iRst = 1'b0;

    applyStimulus("basic", 8'd5, 8'd13, 6'd3, 0, 4, 8'd1, 3, 3);
    applyStimulus("zero shift", 8'd9, 8'd13, 6'd0, 0, 1, 8'd9, 0, 0);
    applyStimulus("carry compare", 8'd254, 8'd255, 6'd1, 0, 2, 8'd253, 1, 0);
    applyStimulus("enable gap", 8'd5, 8'd13, 6'd3, 2, 6, 8'd1, 5, 0);
    applyStimulus("max shift", 8'd1, 8'd251, 6'd63, 0, 64, refModel(1, 251, 63), 63, 1);

    startOnly(8'd5, 8'd13, 6'd10);
    @(posedge iClk);
    #3;
    iRst = 1'b1;
    #1;
    checkOutput("async reset ready", 64'(oReady), 64'(1));
    checkOutput("async reset valid", 64'(oValid), 64'(0));
    checkOutput("async reset busy", 64'(oBusy), 64'(0));
    checkOutput("async reset data", 64'(oData), 64'(0));
    expQ.delete();
    stepCycle();
    iRst = 1'b0;

    startOnly(8'd7, 8'd13, 6'd10);
    stepCycle();
    checkOutput("busy before clear", 64'(oBusy), 64'(1));
    iEn  = 1'b0;
    iClr = 1'b1;
    stepCycle();
    checkOutput("clear ready", 64'(oReady), 64'(1));
    checkOutput("clear busy", 64'(oBusy), 64'(0));
    checkOutput("clear data", 64'(oData), 64'(0));
    iClr = 1'b0;
    iEn  = 1'b1;
    expQ.delete();

    for (int c = 0; c < 3000; c++) begin
      iEn    = ($urandom_range(0, 9) != 0);
      iReady = ($urandom_range(0, 9) < 7);
      iValid = $urandom_range(0, 1) != 0;
      m      = int'($urandom_range(1, 255));
      iMod   = BW'(m);
      iData  = BW'($urandom % 32'(m));
      iShift = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(0, 63)) : SW'($urandom_range(0, 8));
      stepCycle();
    end
    iEn = 1'b1; iReady = 1'b1; iValid = 1'b0;
    guard = 0;
    while ((expQ.size() != 0 || oBusy || oValid) && guard < 200) begin
      stepCycle();
      guard++;
    end
    checkOutput("drain pending results", 64'(expQ.size()), 64'(0));
    checkOutput("drain idle", 64'(oReady), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
